spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- SPI target (mode 0) that lets the host processor act as the initiator of the register-file bus (address, write_en, wr_data, read_en, rd_data).
- Converts serial command/data frames into single-cycle register read and write strobes; returns read data on MISO.
- Sits between the FPGA SPI pins and the motor/servo register file, all in the main clock domain.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer on spi_sclk, spi_cs_n and spi_mosi (≥2).

Ports:
- clock  in  1  main clock; ≥16× SCLK frequency.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, asynchronous, idle low.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  host→FPGA data, MSB first.
- spi_miso  out  1  FPGA→host data, MSB first.
- address  out  6  register-bus address.
- write_en  out  1  one-cycle write strobe.
- wr_data  out  8  write data, valid with write_en.
- read_en  out  1  one-cycle read strobe.
- rd_data  in  8  read data, valid exactly 1 clock after read_en.
- busy  out  1  high while a frame is active (cs_n low, synchronized).
- frame_err  out  1  one-cycle pulse when cs_n deasserts mid-byte.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and shift registers 0; armed=0.
- Sync: the three SPI inputs pass through SYNC_STAGES flops plus one edge-detect flop. Only synchronized values are used.
- armed: set when synchronized cs_n is high. A frame can start only when armed=1, so a frame in progress at reset is ignored until cs_n has gone high.
- Bit counter (3 bits) counts synchronized SCLK rising edges, mod 8.
  - Rising edge: rx_shift <= {rx_shift[6:0], mosi}.
  - Falling edge: tx_shift shifts left only when bit counter != 0.
  - spi_miso = tx_shift[7] whenever busy, else 0.
- Command byte: bit7 = rw (1=read); bit6 = inc (auto-increment); bits5:0 = addr.
- States:
  - IDLE: on cs_n falling with armed=1 → CMD. Set busy=1, clear counter and tx_shift.
  - CMD: on the 8th rising edge, latch rw, inc and addr into address. Then go to RD_REQ if rw=1, else DATA.
  - RD_REQ: read_en=1 for one clock with address valid → RD_WAIT.
  - RD_WAIT: capture rd_data into tx_shift on the next clock → DATA.
  - DATA, rising edge 8:
    - Write frame: write_en=1 and wr_data=rx_shift for one clock, with the current address.
    - Read frame: no strobe.
    - If inc=1: address <= address+1 (6-bit wrap 0x3F→0x00) on the clock after the strobe, or the same clock for reads.
    - Read frame → RD_REQ (prefetch next byte). Write frame → stay in DATA.
  - inc=0: the same address is reused for every data byte (repeated write or re-read).
- cs_n rising (any state) → IDLE, busy=0, miso=0.
  - If bit counter != 0, or state is RD_REQ/RD_WAIT with rising edges pending: pulse frame_err and discard the partial byte.
  - Strobes already issued are not revoked.
- Simultaneous cs_n rise and 8th SCLK rise in the same clock: cs_n wins; byte discarded; frame_err pulses.
- Timing guarantee: the read fetch (3 clocks) plus sync latency (SYNC_STAGES+1) completes within a half SCLK period when clock ≥ 16× SCLK. First MISO bit is valid before the first data rising edge.
- write_en and read_en are never high in the same clock. Each is at most one clock per byte.
- reset mid-frame: outputs return to 0 immediately. No strobe is issued for the interrupted byte.

Test Plan:
- Write: cs_n low, bytes 0x0E, 0x5A, cs_n high → exactly one write_en with address=0x0E, wr_data=0x5A. read_en never asserted. frame_err=0.
- Read: bytes 0x85, 0x00; bus model returns 0x9C 1 clock after read_en → one read_en at address=0x05; MISO during byte 2 = 1,0,0,1,1,1,0,0.
- Burst write with wrap: bytes 0x7E, 0x11, 0x22, 0x33 → writes (0x3E,0x11), (0x3F,0x22), (0x00,0x33), each a single-clock write_en.
- Burst read: bytes 0xC4, 0x00, 0x00, model rd_data = address+0xA0 → read_en at 0x04 then 0x05 (a third prefetch at 0x06 is allowed); MISO returns 0xA4 then 0xA5.
- Abort: bytes 0x04 then 5 bits, cs_n high → no write_en, one frame_err pulse, busy=0. A following write frame 0x06/0x3C writes address 0x06=0x3C correctly.
- Reset mid-frame: assert reset during byte 2 of a write with cs_n held low → outputs 0, no write_en. Remaining SCLKs are ignored. After cs_n high then low, frame 0x08/0x77 writes address 0x08=0x77.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 target driving single-cycle register-bus read/write strobes
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [5:0] address,
  output logic       write_en,
  output logic [7:0] wr_data,
  output logic       read_en,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, RD_WAIT, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic       sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic       armed_q, armed_d, rw_q, rw_d, inc_q, inc_d;
  logic       write_en_q, write_en_d, frame_err_q, frame_err_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, wr_data_q, wr_data_d;
  logic [5:0] address_q, address_d;
  logic       sclk_s, cs_s, mosi_s, rise, fall, cs_rise, cs_fall, last;
  logic [7:0] byte_in;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign byte_in  = {rx_q[6:0], mosi_s};
  assign last     = rise && bit_cnt_q == 3'd7;
  assign address  = address_q;
  assign write_en = write_en_q;
  assign wr_data  = wr_data_q;
  assign frame_err = frame_err_q;
  assign read_en  = state_q == RD_REQ;
  assign busy     = state_q != IDLE;
  assign spi_miso = busy & tx_q[7];

  // Synchronizer chains and edge-detect history for the asynchronous SPI pins
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // Frame FSM: command decode, read prefetch, data shifting and bus strobes
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | cs_s;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    inc_d       = inc_q;
    wr_data_d   = wr_data_q;
    write_en_d  = 1'b0;
    frame_err_d = 1'b0;
    address_d   = (write_en_q && inc_q) ? address_q + 6'd1 : address_q;
    if (state_q == IDLE) begin
      if (cs_fall && armed_q) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        tx_d      = 8'd0;
      end
    end else if (cs_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      frame_err_d = bit_cnt_q != 3'd0;
    end else begin
      if (rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = byte_in;
      end
      if (fall && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
      case (state_q)
        CMD: if (last) begin
          rw_d      = byte_in[7];
          inc_d     = byte_in[6];
          address_d = byte_in[5:0];
          state_d   = byte_in[7] ? RD_REQ : DATA;
        end
        RD_REQ: state_d = RD_WAIT;
        RD_WAIT: begin
          tx_d    = rd_data;
          state_d = DATA;
        end
        DATA: if (last) begin
          if (rw_q) begin
            state_d   = RD_REQ;
            address_d = inc_q ? address_q + 6'd1 : address_q;
          end else begin
            write_en_d = 1'b1;
            wr_data_d  = byte_in;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      inc_q       <= 1'b0;
      wr_data_q   <= 8'd0;
      write_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
      address_q   <= 6'd0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      inc_q       <= inc_d;
      wr_data_q   <= wr_data_d;
      write_en_q  <= write_en_d;
      frame_err_q <= frame_err_d;
      address_q   <= address_d;
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;
  logic       clock, reset, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [5:0] address;
  logic       write_en, read_en, busy, frame_err;
  logic [7:0] wr_data, rd_data;
  logic [7:0] mem [64];
  logic [5:0] wq_a [$];
  logic [7:0] wq_d [$];
  logic [5:0] rq [$];
  int fe_cnt = 0, both_cnt = 0;
  int tests = 0, fails = 0;

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .address(address), .write_en(write_en),
    .wr_data(wr_data), .read_en(read_en), .rd_data(rd_data), .busy(busy), .frame_err(frame_err)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Register-file model: data returned one clock after read_en
  always @(posedge clock) rd_data <= reset ? 8'd0 : (read_en ? mem[address] : rd_data);

  // Bus monitor sampled on the falling clock edge
  always @(negedge clock) begin
    if (write_en) begin
      wq_a.push_back(address);
      wq_d.push_back(wr_data);
    end
    if (read_en) rq.push_back(address);
    if (frame_err) fe_cnt++;
    if (write_en && read_en) both_cnt++;
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #100;
      r[i] = spi_miso;
      spi_sclk = 1;
      #100;
      spi_sclk = 0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    spi_cs_n = 1;
    #300;
  endtask

  task automatic test_reset();
    reset = 1; spi_cs_n = 1; spi_sclk = 0; spi_mosi = 0;
    #100;
    tests++; if ({busy, write_en, read_en, frame_err, spi_miso} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b want 00000", {busy, write_en, read_en, frame_err, spi_miso}); end
    tests++; if ({address, wr_data} !== 14'd0) begin fails++; $display("FAIL reset_bus got %h/%h want 00/00", address, wr_data); end
    reset = 0;
    #300;
  endtask

  task automatic test_write();
    logic [7:0] r;
    int w0 = wq_a.size(), r0 = rq.size(), f0 = fe_cnt;
    cs_low();
    spi_bits(8'h0E, 8, r);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy got %b want 1", busy); end
    spi_bits(8'h5A, 8, r);
    cs_high();
    tests++; if (wq_a.size() - w0 !== 1) begin fails++; $display("FAIL write_count got %0d want 1", wq_a.size() - w0); end
    else begin
      tests++; if (wq_a[w0] !== 6'h0E || wq_d[w0] !== 8'h5A) begin fails++; $display("FAIL write_data got %h=%h want 0e=5a", wq_a[w0], wq_d[w0]); end
    end
    tests++; if (rq.size() - r0 !== 0) begin fails++; $display("FAIL write_noread got %0d want 0", rq.size() - r0); end
    tests++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL write_noerr got %0d want 0", fe_cnt - f0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_idle got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic [7:0] r;
    int w0 = wq_a.size(), r0 = rq.size(), f0 = fe_cnt;
    mem[5] = 8'h9C;
    cs_low();
    spi_bits(8'h85, 8, r);
    spi_bits(8'h00, 8, r);
    cs_high();
    tests++; if (r !== 8'h9C) begin fails++; $display("FAIL read_miso got %h want 9c", r); end
    tests++; if (rq.size() - r0 < 1 || rq.size() - r0 > 2) begin fails++; $display("FAIL read_count got %0d want 1..2", rq.size() - r0); end
    else begin
      tests++; if (rq[r0] !== 6'h05) begin fails++; $display("FAIL read_addr got %h want 05", rq[r0]); end
    end
    tests++; if (wq_a.size() - w0 !== 0) begin fails++; $display("FAIL read_nowrite got %0d want 0", wq_a.size() - w0); end
    tests++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL read_noerr got %0d want 0", fe_cnt - f0); end
    mem[5] = 8'hA5;
  endtask

  task automatic test_burst_write();
    logic [7:0] r;
    logic [5:0] ea [3] = '{6'h3E, 6'h3F, 6'h00};
    logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
    int w0 = wq_a.size();
    cs_low();
    spi_bits(8'h7E, 8, r);
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 8, r);
    spi_bits(8'h33, 8, r);
    cs_high();
    tests++; if (wq_a.size() - w0 !== 3) begin fails++; $display("FAIL bwrite_count got %0d want 3", wq_a.size() - w0); end
    else for (int i = 0; i < 3; i++) begin
      tests++; if (wq_a[w0+i] !== ea[i] || wq_d[w0+i] !== ed[i]) begin fails++; $display("FAIL bwrite_%0d got %h=%h want %h=%h", i, wq_a[w0+i], wq_d[w0+i], ea[i], ed[i]); end
    end
  endtask

  task automatic test_burst_read();
    logic [7:0] r1, r2, r3;
    int r0 = rq.size();
    cs_low();
    spi_bits(8'hC4, 8, r1);
    spi_bits(8'h00, 8, r2);
    spi_bits(8'h00, 8, r3);
    cs_high();
    tests++; if (r2 !== 8'hA4 || r3 !== 8'hA5) begin fails++; $display("FAIL bread_miso got %h,%h want a4,a5", r2, r3); end
    tests++; if (rq.size() - r0 < 2 || rq.size() - r0 > 3) begin fails++; $display("FAIL bread_count got %0d want 2..3", rq.size() - r0); end
    else begin
      tests++; if (rq[r0] !== 6'h04 || rq[r0+1] !== 6'h05) begin fails++; $display("FAIL bread_addr got %h,%h want 04,05", rq[r0], rq[r0+1]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int w0 = wq_a.size(), f0 = fe_cnt;
    cs_low();
    spi_bits(8'h04, 8, r);
    spi_bits(8'hFF, 5, r);
    cs_high();
    tests++; if (wq_a.size() - w0 !== 0) begin fails++; $display("FAIL abort_nowrite got %0d want 0", wq_a.size() - w0); end
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL abort_err got %0d want 1", fe_cnt - f0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle got %b want 0", busy); end
    cs_low();
    spi_bits(8'h06, 8, r);
    spi_bits(8'h3C, 8, r);
    cs_high();
    tests++; if (wq_a.size() - w0 !== 1) begin fails++; $display("FAIL abort_next_count got %0d want 1", wq_a.size() - w0); end
    else begin
      tests++; if (wq_a[w0] !== 6'h06 || wq_d[w0] !== 8'h3C) begin fails++; $display("FAIL abort_next got %h=%h want 06=3c", wq_a[w0], wq_d[w0]); end
    end
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL abort_next_err got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    int w0 = wq_a.size(), f0 = fe_cnt;
    cs_low();
    spi_bits(8'h09, 8, r);
    spi_bits(8'hAA, 3, r);
    reset = 1;
    #20;
    reset = 0;
    tests++; if ({busy, write_en, read_en, frame_err, spi_miso} !== 5'b0) begin fails++; $display("FAIL rst_mid_ctrl got %b want 00000", {busy, write_en, read_en, frame_err, spi_miso}); end
    tests++; if ({address, wr_data} !== 14'd0) begin fails++; $display("FAIL rst_mid_bus got %h/%h want 00/00", address, wr_data); end
    spi_bits(8'hFF, 5, r);
    spi_bits(8'h55, 8, r);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_ignored got %b want 0", busy); end
    cs_high();
    tests++; if (wq_a.size() - w0 !== 0) begin fails++; $display("FAIL rst_mid_nowrite got %0d want 0", wq_a.size() - w0); end
    cs_low();
    spi_bits(8'h08, 8, r);
    spi_bits(8'h77, 8, r);
    cs_high();
    tests++; if (wq_a.size() - w0 !== 1) begin fails++; $display("FAIL rst_next_count got %0d want 1", wq_a.size() - w0); end
    else begin
      tests++; if (wq_a[w0] !== 6'h08 || wq_d[w0] !== 8'h77) begin fails++; $display("FAIL rst_next got %h=%h want 08=77", wq_a[w0], wq_d[w0]); end
    end
    tests++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL rst_next_err got %0d want 0", fe_cnt - f0); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hA0 + 8'(i);
    test_reset();
    test_write();
    test_read();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_reset_mid_frame();
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
